// File: rtl/ux607_qspi_pkg.sv
// Shared encodings for the QSPI staging block: link protocol width and
// chip-select mode.
package ux607_qspi_pkg;

    // Link protocol: number of data lanes is 2**proto.
    typedef enum logic [1:0] {
        PROTO_SINGLE = 2'd0,
        PROTO_DUAL   = 2'd1,
        PROTO_QUAD   = 2'd2,
        PROTO_OCTAL  = 2'd3
    } proto_e;

    // Chip-select mode; encoding 1 is reserved and behaves like AUTO.
    typedef enum logic [1:0] {
        CS_AUTO = 2'd0,
        CS_HOLD = 2'd2,
        CS_OFF  = 2'd3
    } cs_mode_e;

endpackage

// File: rtl/ux607_qspi_sync_fifo.sv
// Synchronous, non-flow-through FIFO with single-cycle flush and occupancy count.
// Flush wins over a same-cycle enqueue or dequeue.
module ux607_qspi_sync_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    input  logic [DW-1:0]              enq_bits,
    input  logic                       deq_ready,
    output logic                       deq_valid,
    output logic [DW-1:0]              deq_bits,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          enq_fire, deq_fire;

    assign enq_ready = (count != CW'(DEPTH));
    assign deq_valid = (count != '0);
    assign deq_bits  = mem[rptr];
    assign enq_fire  = enq_valid & enq_ready;
    assign deq_fire  = deq_ready & deq_valid;

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clock) begin
        if (enq_fire && !flush)
            mem[wptr] <= enq_bits;
    end

    // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (enq_fire) wptr <= wptr + 1'b1;
            if (deq_fire) rptr <= rptr + 1'b1;
            case ({enq_fire, deq_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ux607_qspi_fifo_p.sv
// QSPI TX/RX staging between register front-end and link engine.
// Optional sticky error flags enabled by defining QSPI_FIFO_ERR_EN.
module ux607_qspi_fifo_p
    import ux607_qspi_pkg::*;
#(
    parameter  int DW    = 8,
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(DEPTH) + 1,
    localparam int LW    = $clog2(DW) + 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [1:0]    io_ctrl_fmt_proto,
    input  logic          io_ctrl_fmt_endian,
    input  logic          io_ctrl_fmt_iodir,
    input  logic [LW-1:0] io_ctrl_fmt_len,
    input  logic [1:0]    io_ctrl_cs_mode,
    input  logic [CW-1:0] io_ctrl_wm_tx,
    input  logic [CW-1:0] io_ctrl_wm_rx,
    input  logic          io_ctrl_flush_tx,
    input  logic          io_ctrl_flush_rx,
    input  logic          io_ctrl_err_clr,
    input  logic          io_link_tx_ready,
    output logic          io_link_tx_valid,
    output logic [DW-1:0] io_link_tx_bits,
    input  logic          io_link_rx_valid,
    input  logic [DW-1:0] io_link_rx_bits,
    output logic [LW-1:0] io_link_cnt,
    output logic [1:0]    io_link_fmt_proto,
    output logic          io_link_fmt_endian,
    output logic          io_link_fmt_iodir,
    output logic          io_link_cs_set,
    output logic          io_link_cs_clear,
    output logic          io_link_cs_hold,
    input  logic          io_link_active,
    output logic          io_link_lock,
    output logic          io_tx_ready,
    input  logic          io_tx_valid,
    input  logic [DW-1:0] io_tx_bits,
    input  logic          io_rx_ready,
    output logic          io_rx_valid,
    output logic [DW-1:0] io_rx_bits,
    output logic [CW-1:0] io_tx_count,
    output logic [CW-1:0] io_rx_count,
    output logic          io_ip_txwm,
    output logic          io_ip_rxwm,
    output logic          io_err_txovf,
    output logic          io_err_rxovf,
    output logic          io_err_rxudf
);

    logic          fire_tx, rxen, rx_enq, rx_enq_ready;
    logic [1:0]    cs_mode_q;
    logic [LW-1:0] len_c;
    logic [LW:0]   cnt_sum, cnt_shr;
    logic          tx_ovf_set, rx_ovf_set, rx_udf_set;
    logic          unused_active;

    assign unused_active = io_link_active;

    ux607_qspi_sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_tx_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (io_ctrl_flush_tx),
        .enq_valid (io_tx_valid),
        .enq_ready (io_tx_ready),
        .enq_bits  (io_tx_bits),
        .deq_ready (io_link_tx_ready),
        .deq_valid (io_link_tx_valid),
        .deq_bits  (io_link_tx_bits),
        .count     (io_tx_count)
    );

    ux607_qspi_sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_rx_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (io_ctrl_flush_rx),
        .enq_valid (rx_enq),
        .enq_ready (rx_enq_ready),
        .enq_bits  (io_link_rx_bits),
        .deq_ready (io_rx_ready),
        .deq_valid (io_rx_valid),
        .deq_bits  (io_rx_bits),
        .count     (io_rx_count)
    );

    assign fire_tx = io_link_tx_valid & io_link_tx_ready;
    assign rx_enq  = io_link_rx_valid & rxen;

    // RX capture window: opened by a transmitted frame (unless TX-only),
    // closed by the first returning link beat.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)              rxen <= 1'b0;
        else if (fire_tx)          rxen <= ~io_ctrl_fmt_iodir;
        else if (io_link_rx_valid) rxen <= 1'b0;
    end

    // Registered copy of cs mode; a difference from the live input flags a change.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cs_mode_q <= CS_AUTO;
        else          cs_mode_q <= io_ctrl_cs_mode;
    end

    assign io_link_cs_set   = (cs_mode_q != CS_OFF);
    assign io_link_cs_hold  = (cs_mode_q == CS_HOLD);
    assign io_link_cs_clear = (cs_mode_q != io_ctrl_cs_mode) |
                              (fire_tx & (cs_mode_q != CS_HOLD) & (cs_mode_q != CS_OFF));
    assign io_link_lock     = io_link_tx_valid | rxen;

    // Beats per frame = ceil(len / lanes), with len clamped to the frame width.
    assign len_c       = (io_ctrl_fmt_len > LW'(DW)) ? LW'(DW) : io_ctrl_fmt_len;
    assign cnt_sum     = {1'b0, len_c} + (((LW+1)'(1)) << io_ctrl_fmt_proto) - (LW+1)'(1);
    assign cnt_shr     = cnt_sum >> io_ctrl_fmt_proto;
    assign io_link_cnt = cnt_shr[LW-1:0];

    assign io_link_fmt_proto  = io_ctrl_fmt_proto;
    assign io_link_fmt_endian = io_ctrl_fmt_endian;
    assign io_link_fmt_iodir  = io_ctrl_fmt_iodir;

    assign io_ip_txwm = (io_tx_count < io_ctrl_wm_tx);
    assign io_ip_rxwm = (io_rx_count > io_ctrl_wm_rx);

    assign tx_ovf_set = io_tx_valid & ~io_tx_ready;
    assign rx_ovf_set = rx_enq & ~rx_enq_ready;
    assign rx_udf_set = io_rx_ready & ~io_rx_valid;

`ifdef QSPI_FIFO_ERR_EN
    logic txovf, rxovf, rxudf;

    // Sticky error flags; clear takes priority over a same-cycle set.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            txovf <= 1'b0;
            rxovf <= 1'b0;
            rxudf <= 1'b0;
        end else if (io_ctrl_err_clr) begin
            txovf <= 1'b0;
            rxovf <= 1'b0;
            rxudf <= 1'b0;
        end else begin
            txovf <= txovf | tx_ovf_set;
            rxovf <= rxovf | rx_ovf_set;
            rxudf <= rxudf | rx_udf_set;
        end
    end

    assign io_err_txovf = txovf;
    assign io_err_rxovf = rxovf;
    assign io_err_rxudf = rxudf;
`else
    logic unused_err;
    assign unused_err   = ^{io_ctrl_err_clr, tx_ovf_set, rx_ovf_set, rx_udf_set};
    assign io_err_txovf = 1'b0;
    assign io_err_rxovf = 1'b0;
    assign io_err_rxudf = 1'b0;
`endif

endmodule

// File: tb/tb_ux607_qspi_fifo_p.sv
// Scoreboard bench for ux607_qspi_fifo_p: the driver issues stimulus and keeps
// a queue-based reference model; a negedge monitor compares every output.
module tb_ux607_qspi_fifo_p;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int LW    = $clog2(DW) + 1;
`ifdef QSPI_FIFO_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clock, reset_n;
    logic [1:0]    io_ctrl_fmt_proto;
    logic          io_ctrl_fmt_endian, io_ctrl_fmt_iodir;
    logic [LW-1:0] io_ctrl_fmt_len;
    logic [1:0]    io_ctrl_cs_mode;
    logic [CW-1:0] io_ctrl_wm_tx, io_ctrl_wm_rx;
    logic          io_ctrl_flush_tx, io_ctrl_flush_rx, io_ctrl_err_clr;
    logic          io_link_tx_ready, io_link_tx_valid;
    logic [DW-1:0] io_link_tx_bits;
    logic          io_link_rx_valid;
    logic [DW-1:0] io_link_rx_bits;
    logic [LW-1:0] io_link_cnt;
    logic [1:0]    io_link_fmt_proto;
    logic          io_link_fmt_endian, io_link_fmt_iodir;
    logic          io_link_cs_set, io_link_cs_clear, io_link_cs_hold;
    logic          io_link_active, io_link_lock;
    logic          io_tx_ready, io_tx_valid;
    logic [DW-1:0] io_tx_bits;
    logic          io_rx_ready, io_rx_valid;
    logic [DW-1:0] io_rx_bits;
    logic [CW-1:0] io_tx_count, io_rx_count;
    logic          io_ip_txwm, io_ip_rxwm;
    logic          io_err_txovf, io_err_rxovf, io_err_rxudf;

    ux607_qspi_fifo_p #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n),
        .io_ctrl_fmt_proto(io_ctrl_fmt_proto), .io_ctrl_fmt_endian(io_ctrl_fmt_endian),
        .io_ctrl_fmt_iodir(io_ctrl_fmt_iodir), .io_ctrl_fmt_len(io_ctrl_fmt_len),
        .io_ctrl_cs_mode(io_ctrl_cs_mode), .io_ctrl_wm_tx(io_ctrl_wm_tx),
        .io_ctrl_wm_rx(io_ctrl_wm_rx), .io_ctrl_flush_tx(io_ctrl_flush_tx),
        .io_ctrl_flush_rx(io_ctrl_flush_rx), .io_ctrl_err_clr(io_ctrl_err_clr),
        .io_link_tx_ready(io_link_tx_ready), .io_link_tx_valid(io_link_tx_valid),
        .io_link_tx_bits(io_link_tx_bits), .io_link_rx_valid(io_link_rx_valid),
        .io_link_rx_bits(io_link_rx_bits), .io_link_cnt(io_link_cnt),
        .io_link_fmt_proto(io_link_fmt_proto), .io_link_fmt_endian(io_link_fmt_endian),
        .io_link_fmt_iodir(io_link_fmt_iodir), .io_link_cs_set(io_link_cs_set),
        .io_link_cs_clear(io_link_cs_clear), .io_link_cs_hold(io_link_cs_hold),
        .io_link_active(io_link_active), .io_link_lock(io_link_lock),
        .io_tx_ready(io_tx_ready), .io_tx_valid(io_tx_valid), .io_tx_bits(io_tx_bits),
        .io_rx_ready(io_rx_ready), .io_rx_valid(io_rx_valid), .io_rx_bits(io_rx_bits),
        .io_tx_count(io_tx_count), .io_rx_count(io_rx_count),
        .io_ip_txwm(io_ip_txwm), .io_ip_rxwm(io_ip_rxwm),
        .io_err_txovf(io_err_txovf), .io_err_rxovf(io_err_rxovf), .io_err_rxudf(io_err_rxudf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int            cnt_tx, cnt_rx;
    bit            rxen_m;
    bit [1:0]      cs_m;
    bit            e_txovf, e_rxovf, e_rxudf;
    logic [DW-1:0] exp_tx[$];
    logic [DW-1:0] exp_rx[$];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Beats per frame from the protocol rule: ceil(min(len,DW) / lanes).
    function automatic int ref_cnt(int len, int proto);
        int l, lanes;
        l     = (len > DW) ? DW : len;
        lanes = 1 << proto;
        return (l + lanes - 1) / lanes;
    endfunction

    function automatic void reset_model();
        cnt_tx = 0; cnt_rx = 0; rxen_m = 0; cs_m = 0;
        e_txovf = 0; e_rxovf = 0; e_rxudf = 0;
        exp_tx.delete(); exp_rx.delete();
    endfunction

    // Advance the model by one clock edge using the inputs held across it.
    function automatic void model_update();
        bit tx_deq, tx_enq, rx_enq, rx_deq;
        if (!reset_n) return;
        tx_deq = io_link_tx_ready && cnt_tx != 0;
        tx_enq = io_tx_valid && cnt_tx != DEPTH;
        rx_enq = io_link_rx_valid && rxen_m && cnt_rx != DEPTH;
        rx_deq = io_rx_ready && cnt_rx != 0;
        if (io_ctrl_err_clr) begin
            e_txovf = 0; e_rxovf = 0; e_rxudf = 0;
        end else begin
            if (io_tx_valid && cnt_tx == DEPTH) e_txovf = 1;
            if (io_link_rx_valid && rxen_m && cnt_rx == DEPTH) e_rxovf = 1;
            if (io_rx_ready && cnt_rx == 0) e_rxudf = 1;
        end
        if (io_ctrl_flush_tx) begin
            cnt_tx = 0; exp_tx.delete();
        end else begin
            if (tx_enq) exp_tx.push_back(io_tx_bits);
            cnt_tx = cnt_tx + int'(tx_enq) - int'(tx_deq);
        end
        if (io_ctrl_flush_rx) begin
            cnt_rx = 0; exp_rx.delete();
        end else begin
            if (rx_enq) exp_rx.push_back(io_link_rx_bits);
            cnt_rx = cnt_rx + int'(rx_enq) - int'(rx_deq);
        end
        if (tx_deq) rxen_m = !io_ctrl_fmt_iodir;
        else if (io_link_rx_valid) rxen_m = 0;
        cs_m = io_ctrl_cs_mode;
    endfunction

    task automatic tick();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic quiet();
        io_tx_valid = 0; io_link_tx_ready = 0; io_link_rx_valid = 0; io_rx_ready = 0;
        io_ctrl_flush_tx = 0; io_ctrl_flush_rx = 0; io_ctrl_err_clr = 0;
        io_ctrl_cs_mode = 0;
    endtask

    task automatic reset_chk(string tag);
        chk({tag, "_link_tx_valid"}, io_link_tx_valid, 0);
        chk({tag, "_rx_valid"}, io_rx_valid, 0);
        chk({tag, "_tx_ready"}, io_tx_ready, 1);
        chk({tag, "_lock"}, io_link_lock, 0);
        chk({tag, "_cs_set"}, io_link_cs_set, 1);
        chk({tag, "_cs_clear"}, io_link_cs_clear, 0);
        chk({tag, "_cs_hold"}, io_link_cs_hold, 0);
        chk({tag, "_counts"}, {io_tx_count, io_rx_count}, 0);
        chk({tag, "_txwm"}, io_ip_txwm, io_ctrl_wm_tx > 0);
        chk({tag, "_rxwm"}, io_ip_rxwm, 0);
        chk({tag, "_errs"}, {io_err_txovf, io_err_rxovf, io_err_rxudf}, 0);
    endtask

    // Monitor: compares every output against the model, pops scoreboards on handshakes.
    always @(negedge clock) begin
        if (reset_n) begin
            bit fire;
            logic [DW-1:0] e;
            fire = (cnt_tx != 0) && io_link_tx_ready;
            chk("tx_ready", io_tx_ready, cnt_tx != DEPTH);
            chk("link_tx_valid", io_link_tx_valid, cnt_tx != 0);
            chk("rx_valid", io_rx_valid, cnt_rx != 0);
            chk("tx_count", io_tx_count, cnt_tx);
            chk("rx_count", io_rx_count, cnt_rx);
            chk("lock", io_link_lock, (cnt_tx != 0) || rxen_m);
            chk("cs_set", io_link_cs_set, cs_m != 3);
            chk("cs_hold", io_link_cs_hold, cs_m == 2);
            chk("cs_clear", io_link_cs_clear,
                (cs_m != io_ctrl_cs_mode) || (fire && cs_m != 2 && cs_m != 3));
            chk("link_cnt", io_link_cnt, ref_cnt(io_ctrl_fmt_len, io_ctrl_fmt_proto));
            chk("txwm", io_ip_txwm, cnt_tx < io_ctrl_wm_tx);
            chk("rxwm", io_ip_rxwm, cnt_rx > io_ctrl_wm_rx);
            chk("txovf", io_err_txovf, ERR_EN & e_txovf);
            chk("rxovf", io_err_rxovf, ERR_EN & e_rxovf);
            chk("rxudf", io_err_rxudf, ERR_EN & e_rxudf);
            chk("fmt_pass", {io_link_fmt_proto, io_link_fmt_endian, io_link_fmt_iodir},
                {io_ctrl_fmt_proto, io_ctrl_fmt_endian, io_ctrl_fmt_iodir});
            if (io_link_tx_valid && io_link_tx_ready) begin
                n_cmp++;
                if (exp_tx.size() == 0) begin
                    n_bad++;
                    $display("FAIL tx_data: got %0h expected no frame at %0t", io_link_tx_bits, $time);
                end else begin
                    n_cmp--;
                    e = exp_tx.pop_front();
                    chk("tx_data", io_link_tx_bits, e);
                end
            end
            if (io_rx_valid && io_rx_ready) begin
                n_cmp++;
                if (exp_rx.size() == 0) begin
                    n_bad++;
                    $display("FAIL rx_data: got %0h expected no frame at %0t", io_rx_bits, $time);
                end else begin
                    n_cmp--;
                    e = exp_rx.pop_front();
                    chk("rx_data", io_rx_bits, e);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        n_bad++;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_lc[4];
        int bias;
        exp_lc = '{9, 5, 3, 2};
        reset_n = 0;
        quiet();
        io_ctrl_fmt_proto = 0; io_ctrl_fmt_endian = 0; io_ctrl_fmt_iodir = 1;
        io_ctrl_fmt_len = 8; io_ctrl_wm_tx = 4; io_ctrl_wm_rx = 2;
        io_tx_bits = 0; io_link_rx_bits = 0; io_link_active = 0;
        reset_model();
        #3 reset_chk("rst");
        tick(); tick();
        reset_n = 1;

        // TX full: 9th write refused, overflow flagged, watermark low at 8.
        for (int i = 0; i < 9; i++) begin
            io_tx_valid = 1; io_tx_bits = DW'($urandom);
            if (i == 8) chk("full_tx_ready", io_tx_ready, 0);
            tick();
        end
        io_tx_valid = 0;
        chk("full_txovf", io_err_txovf, ERR_EN);
        chk("full_txwm", io_ip_txwm, 0);
        chk("full_count", io_tx_count, 8);
        io_link_tx_ready = 1;
        repeat (9) tick();
        io_link_tx_ready = 0;
        io_ctrl_err_clr = 1; tick(); io_ctrl_err_clr = 0;

        // Receive-during-transmit: one frame out, one beat back.
        io_ctrl_fmt_iodir = 0;
        io_tx_valid = 1; io_tx_bits = 16'h1234; tick();
        io_tx_valid = 0; io_link_tx_ready = 1; tick();
        io_link_tx_ready = 0;
        chk("rxen_lock", io_link_lock, 1);
        io_link_rx_valid = 1; io_link_rx_bits = 16'h00A5; tick();
        io_link_rx_valid = 0;
        chk("rx_valid_a5", io_rx_valid, 1);
        chk("rx_bits_a5", io_rx_bits, 32'hA5);
        chk("lock_drop", io_link_lock, 0);
        io_rx_ready = 1; tick(); io_rx_ready = 0;

        // RX full: ninth beat dropped, overflow flagged then cleared.
        for (int i = 0; i < 9; i++) begin
            io_tx_valid = 1; io_tx_bits = DW'($urandom); tick();
            io_tx_valid = 0; io_link_tx_ready = 1; tick();
            io_link_tx_ready = 0; io_link_rx_valid = 1; io_link_rx_bits = DW'($urandom); tick();
            io_link_rx_valid = 0;
        end
        chk("rxfull_count", io_rx_count, 8);
        chk("rxfull_rxovf", io_err_rxovf, ERR_EN);
        io_ctrl_err_clr = 1; tick(); io_ctrl_err_clr = 0;
        chk("rxovf_clr", io_err_rxovf, 0);
        io_rx_ready = 1; repeat (9) tick(); io_rx_ready = 0;
        chk("rxudf", io_err_rxudf, ERR_EN);
        io_ctrl_err_clr = 1; tick(); io_ctrl_err_clr = 0;

        // Beat count per protocol, and clamping.
        for (int p = 0; p < 4; p++) begin
            io_ctrl_fmt_proto = p[1:0]; io_ctrl_fmt_len = 9; tick();
            chk("link_cnt_len9", io_link_cnt, exp_lc[p]);
        end
        io_ctrl_fmt_proto = 0; io_ctrl_fmt_len = 20; tick();
        chk("link_cnt_clamp", io_link_cnt, 16);
        io_ctrl_fmt_len = 0; tick();
        chk("link_cnt_zero", io_link_cnt, 0);

        // Chip-select sequencing.
        io_ctrl_fmt_iodir = 1; io_ctrl_cs_mode = 0; tick();
        io_ctrl_cs_mode = 2; #1;
        chk("cs_change_clear", io_link_cs_clear, 1);
        tick();
        chk("cs_hold_clear", io_link_cs_clear, 0);
        chk("cs_hold", io_link_cs_hold, 1);
        io_ctrl_cs_mode = 0; tick(); tick();
        io_tx_valid = 1; tick();
        io_tx_valid = 0; io_link_tx_ready = 1; #1;
        chk("cs_auto_fire", io_link_cs_clear, 1);
        tick();
        io_link_tx_ready = 0; #1;
        chk("cs_auto_idle", io_link_cs_clear, 0);
        io_ctrl_cs_mode = 3; tick(); tick();
        chk("cs_off_set", io_link_cs_set, 0);
        io_ctrl_cs_mode = 0; tick();

        // Flush with a simultaneous write.
        repeat (3) begin io_tx_valid = 1; io_tx_bits = DW'($urandom); tick(); end
        io_ctrl_flush_tx = 1; tick();
        io_ctrl_flush_tx = 0; io_tx_valid = 0;
        chk("flush_count", io_tx_count, 0);
        chk("flush_valid", io_link_tx_valid, 0);

        // Asynchronous reset in the middle of a transfer.
        io_ctrl_fmt_iodir = 0;
        repeat (4) begin io_tx_valid = 1; io_tx_bits = DW'($urandom); tick(); end
        io_tx_valid = 0; io_link_tx_ready = 1; tick();
        reset_n = 0;
        quiet();
        #1 reset_chk("midrst");
        reset_model();
        tick();
        reset_n = 1;

        // Randomized traffic with alternating fill/drain bias.
        for (int c = 0; c < 3000; c++) begin
            bias = ((c / 300) % 2 == 0) ? 70 : 30;
            io_tx_valid       = $urandom_range(0, 99) < bias;
            io_tx_bits        = DW'($urandom);
            io_link_tx_ready  = $urandom_range(0, 99) < (100 - bias);
            io_link_rx_valid  = $urandom_range(0, 99) < 35;
            io_link_rx_bits   = DW'($urandom);
            io_rx_ready       = $urandom_range(0, 99) < (100 - bias);
            io_ctrl_flush_tx  = $urandom_range(0, 99) < 2;
            io_ctrl_flush_rx  = $urandom_range(0, 99) < 2;
            io_ctrl_err_clr   = $urandom_range(0, 99) < 5;
            io_ctrl_fmt_iodir = $urandom_range(0, 99) < 30;
            io_ctrl_fmt_endian = 1'($urandom);
            io_ctrl_fmt_proto = 2'($urandom);
            io_ctrl_fmt_len   = LW'($urandom_range(0, 31));
            if ($urandom_range(0, 99) < 8) io_ctrl_cs_mode = 2'($urandom);
            if ($urandom_range(0, 99) < 5) begin
                io_ctrl_wm_tx = CW'($urandom_range(0, DEPTH));
                io_ctrl_wm_rx = CW'($urandom_range(0, DEPTH));
            end
            tick();
        end
        quiet();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ux607_qspi_fifo_p.md
# ux607_qspi_fifo_p

Parametrised TX/RX staging block between the QSPI register front-end and the QSPI physical link engine. It buffers outbound and inbound frames in two internal synchronous FIFOs of configurable width and depth. It derives the per-frame link beat count for single, dual, quad and octal protocols, and manages chip-select sequencing and RX capture gating. It also provides watermark interrupts, per-queue flush and optional sticky overflow/underflow error flags.

## Interface
Parameters:
- DW, 8, frame data width in bits (8, 16 or 32)
- DEPTH, 8, entries per FIFO; power of two, ≥2
- CW, $clog2(DEPTH)+1, occupancy count width (derived; not overridden)
- LW, $clog2(DW)+1, frame length field width (derived)

Ports:
- clock  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- io_ctrl_fmt_proto  in  2  0 single, 1 dual, 2 quad, 3 octal
- io_ctrl_fmt_endian  in  1  passed to link
- io_ctrl_fmt_iodir  in  1  0 = receive during transmit, 1 = transmit only
- io_ctrl_fmt_len  in  LW  bits per frame
- io_ctrl_cs_mode  in  2  0 auto, 1 reserved (acts as auto), 2 hold, 3 off
- io_ctrl_wm_tx / io_ctrl_wm_rx  in  CW  watermarks
- io_ctrl_flush_tx / io_ctrl_flush_rx  in  1  single-cycle queue clear
- io_ctrl_err_clr  in  1  clears sticky error flags
- io_link_tx_ready  in  1 / io_link_tx_valid  out  1 / io_link_tx_bits  out  DW  link TX handshake
- io_link_rx_valid  in  1 / io_link_rx_bits  in  DW  link RX data (no backpressure)
- io_link_cnt  out  LW  link beats per frame
- io_link_fmt_proto / _endian / _iodir  out  2/1/1  format passthrough
- io_link_cs_set / io_link_cs_clear / io_link_cs_hold  out  1  chip-select controls
- io_link_active  in  1  link busy (informational)
- io_link_lock  out  1  link must not release
- io_tx_ready  out  1 / io_tx_valid  in  1 / io_tx_bits  in  DW  host TX enqueue
- io_rx_ready  in  1 / io_rx_valid  out  1 / io_rx_bits  out  DW  host RX dequeue
- io_tx_count / io_rx_count  out  CW  occupancy
- io_ip_txwm / io_ip_rxwm  out  1  watermark interrupts
- io_err_txovf / io_err_rxovf / io_err_rxudf  out  1  sticky errors

## Operation
- Each FIFO is non-flow-through: enq_ready = count≠DEPTH; deq_valid = count≠0; deq_bits is read combinationally from the head entry. Enqueue and dequeue in the same cycle leave the count unchanged.
- Link TX is the TX FIFO head. fire_tx = io_link_tx_valid & io_link_tx_ready.
- rxen register: on fire_tx it loads !iodir; otherwise io_link_rx_valid clears it. RX enqueue = io_link_rx_valid & rxen.
- RX enqueue when the RX FIFO is full: the data is dropped, the count is held, and rxovf is set.
- Host TX write when full (io_tx_valid & !io_tx_ready): the data is ignored and txovf is set. Host RX read when empty (io_rx_ready & !io_rx_valid): rxudf is set.
- io_link_cnt = ceil(len / 2^proto); len > DW is clamped to DW; len 0 gives 0.
- cs_mode register tracks io_ctrl_cs_mode every cycle. cs_set = mode≠off; cs_hold = mode==hold; cs_clear = (reg≠input) | (fire_tx & mode∉{hold,off}).
- io_link_lock = io_link_tx_valid | rxen.
- io_ip_txwm = tx_count < wm_tx; io_ip_rxwm = rx_count > wm_rx (unsigned).
- Flush zeroes the pointers and count of its queue. Flush beats enqueue and dequeue in the same cycle; a write or read accepted that cycle is discarded.
- Error flag priority: err_clr beats a same-cycle set.

## Timing
- Reset values: rxen 0, cs_mode 0, pointers/counts 0, errors 0. Consequently tx_valid 0, rx_valid 0, tx_ready 1, lock 0, cs_set 1, cs_clear 0, txwm = (wm_tx>0), rxwm 0.
- Enqueue-to-dequeue latency is 1 cycle. io_*_count updates 1 cycle after the handshake.
- rxen is 1 from the cycle after fire_tx through the cycle of the first io_link_rx_valid.
- Flush takes effect on the next edge.
- Pointers wrap modulo DEPTH.

## Configuration
- QSPI_FIFO_ERR_EN defined: the txovf, rxovf and rxudf registers and io_ctrl_err_clr are live.
- QSPI_FIFO_ERR_EN undefined: the error outputs are tied 0, io_ctrl_err_clr is ignored, and no error registers exist. Drop and ignore behaviour is unchanged.

## Structure
- Shared package ux607_qspi_pkg holds the proto enum (SINGLE/DUAL/QUAD/OCTAL) and the cs_mode enum (AUTO/HOLD/OFF) with their encodings.
- Sub-module ux607_qspi_sync_fifo (DW, DEPTH) provides enq/deq handshakes, flush and count. It is instantiated twice.

## Test plan
- Write 8 frames with DEPTH=8: the 9th write sees tx_ready=0; txovf=1 after the 9th attempt; txwm with wm_tx=4 is 0 at count 8.
- iodir=0, fire_tx, then link rx_valid with 0xA5: rx_valid=1 next cycle, rx_bits=0xA5, rxen back to 0, lock drops.
- RX full with a further link beat: count stays 8, rxovf=1; err_clr clears it next cycle.
- len=9, proto 0/1/2/3 (DW=16): link_cnt = 9/5/3/2; len=20 clamps to 16.
- cs_mode 0→2: cs_clear=1 for one cycle, cs_hold=1; in auto mode each fire_tx pulses cs_clear; mode 3 gives cs_set=0.
- flush_tx with a simultaneous write at count 3: count 0 next cycle, tx_valid=0. Reset_n asserted mid-transfer: all outputs return to their reset values immediately.
